apb_master: RTL
===============

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, APB address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, APB read/write data width in bits.
REQ-003 Parameter TIMEOUT, default 16, ACCESS wait-cycle limit; used only when APB_TIMEOUT_EN is defined.
REQ-004 PCLK  input  1  single clock; all state changes on its rising edge.
REQ-005 PRESET  input  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  input  1  command request from the local side.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_WIDTH  transfer address.
REQ-010 cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  one-cycle pulse: transfer complete.
REQ-012 rsp_rdata  output  DATA_WIDTH  read data; valid with rsp_valid.
REQ-013 rsp_slverr  output  1  error status; valid with rsp_valid.
REQ-014 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-015 PADDR  output  ADDR_WIDTH;  PWDATA  output  DATA_WIDTH  APB address and write data.
REQ-016 PREADY, PSLVERR  input  1 each;  PRDATA  input  DATA_WIDTH  completer response.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SETUP, ACCESS.
REQ-018 cmd_ready SHALL be 1 only in IDLE and SHALL be a registered output.
REQ-019 Command accept: cmd_valid=1 and cmd_ready=1 at a rising edge; go to SETUP; register cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA.
REQ-020 SETUP: PSEL=1, PENABLE=0 for exactly one cycle; then ACCESS unconditionally.
REQ-021 ACCESS: PSEL=1, PENABLE=1; stay while PREADY=0.
REQ-022 PADDR, PWRITE, PWDATA SHALL be held stable from SETUP through the final ACCESS cycle.
REQ-023 ACCESS with PREADY=1 at an edge: go to IDLE, PSEL=PENABLE=0 next cycle, rsp_valid=1 for that one cycle.
REQ-024 Completion capture: rsp_slverr=PSLVERR; rsp_rdata=PRDATA on reads; rsp_rdata=0 on writes.
REQ-025 rsp_rdata and rsp_slverr SHALL hold their values until the next completion.
REQ-026 Zero-wait latency: accept edge to rsp_valid high = 3 cycles; each PREADY=0 ACCESS cycle adds 1.
REQ-027 Back-to-back: cmd_valid held high SHALL be accepted in the IDLE cycle that carries rsp_valid; PSEL therefore drops for at least one cycle between transfers.
REQ-028 PREADY, PRDATA, PSLVERR SHALL be ignored outside ACCESS.
REQ-029 Response channel has no backpressure; rsp_valid is never stretched.

Reset
REQ-030 PRESET=1 SHALL force, without waiting for a clock edge: state=IDLE, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, cmd_ready=0.
REQ-031 cmd_ready SHALL rise on the first PCLK edge after PRESET deasserts.
REQ-032 Reset during SETUP or ACCESS SHALL abort the transfer with no rsp_valid pulse.

Configuration
REQ-033 Macro APB_TIMEOUT_EN defined: a counter SHALL count consecutive ACCESS cycles with PREADY=0; on reaching TIMEOUT, go to IDLE with rsp_valid=1, rsp_slverr=1, rsp_rdata=0.
REQ-034 The timeout counter SHALL clear on entry to SETUP; PREADY=1 in the same cycle the limit is reached SHALL complete normally.
REQ-035 Macro APB_TIMEOUT_EN undefined: no counter is built, TIMEOUT is ignored, ACCESS waits indefinitely.

Verification
REQ-036 Write, zero wait: cmd addr=0x10, wdata=0xDEADBEEF, PREADY=1 -> one SETUP cycle then one ACCESS cycle, PWDATA=0xDEADBEEF, rsp_valid 3 cycles after accept, rsp_slverr=0, rsp_rdata=0.
REQ-037 Read, 2 wait cycles: addr=0x24, PREADY low 2 ACCESS cycles, PRDATA=0xA5A5_0001 -> rsp_rdata=0xA55A0001 is wrong; rsp_rdata=0xA5A50001 and rsp_valid 5 cycles after accept, PADDR stable throughout.
REQ-038 Error: write with PSLVERR=1 at PREADY=1 -> rsp_slverr=1 for that response; next zero-wait read with PSLVERR=0 -> rsp_slverr=0.
REQ-039 Back-to-back: cmd_valid held high for 3 commands, PREADY=1 -> 3 rsp_valid pulses 3 cycles apart, PSEL low exactly one cycle between transfers.
REQ-040 Reset mid-ACCESS: assert PRESET asynchronously between edges during a wait -> PSEL and PENABLE go to 0 immediately, no rsp_valid, cmd_ready=1 one edge after release.
REQ-041 APB_TIMEOUT_EN, TIMEOUT=4, PREADY held 0 -> after 4 ACCESS cycles: rsp_valid=1, rsp_slverr=1, PSEL=0; without the macro the bench confirms PSEL is still 1 after 100 cycles.

Source files
------------

// File: rtl/apb_master.sv
// APB master: accepts one local command at a time and runs it as an
// APB SETUP/ACCESS transfer, returning a single-cycle response pulse.
// Optional feature macro: APB_TIMEOUT_EN. When defined, an ACCESS phase
// that sees TIMEOUT consecutive PREADY=0 cycles ends with an error response.
module apb_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_cmd_ready;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_slverr;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;

    logic                    w_accept;
    logic [DATA_WIDTH-1:0]   w_rdata_cap;

`ifdef APB_TIMEOUT_EN
    // Counter only needs to reach TIMEOUT-1; the next stalled cycle fires.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0]        r_to_cnt;
    logic                    w_to_hit;
    assign w_to_hit = (r_to_cnt == CNT_W'(TIMEOUT - 1));
`else
    // TIMEOUT has no effect in this build; ACCESS waits for PREADY forever.
    logic                    w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    assign w_accept    = cmd_valid & r_cmd_ready;
    // Writes return zero read data so stale PRDATA never leaks out.
    assign w_rdata_cap = r_pwrite ? '0 : PRDATA;

    // Transfer FSM; every output is a register updated here.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state      <= IDLE;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_slverr <= 1'b0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
`ifdef APB_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state     <= SETUP;
                        r_cmd_ready <= 1'b0;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                        r_pwrite    <= cmd_write;
                        r_paddr     <= cmd_addr;
                        r_pwdata    <= cmd_wdata;
`ifdef APB_TIMEOUT_EN
                        r_to_cnt    <= '0;
`endif
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    // PREADY wins over a timeout reached in the same cycle.
                    if (PREADY) begin
                        r_state      <= IDLE;
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_cmd_ready  <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_slverr <= PSLVERR;
                        r_rsp_rdata  <= w_rdata_cap;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (w_to_hit) begin
                        r_state      <= IDLE;
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_cmd_ready  <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_slverr <= 1'b1;
                        r_rsp_rdata  <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state     <= IDLE;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_slverr = r_rsp_slverr;
    assign PSEL       = r_psel;
    assign PENABLE    = r_penable;
    assign PWRITE     = r_pwrite;
    assign PADDR      = r_paddr;
    assign PWDATA     = r_pwdata;

endmodule
